// File: rtl/uart_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_pkg: shared types and helpers for the UART transmit path.   Rev 1.0
// ----------------------------------------------------------------------------
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } tx_state_t;

   localparam int PARITY_EVEN = 0;
   localparam int PARITY_ODD  = 1;

   // Bits needed to hold a count of 0..n inclusive.
   function automatic int count_width(input int n);
      return $clog2(n + 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sync_fifo: single-clock first-word-fall-through queue.           Rev 1.0
// ----------------------------------------------------------------------------
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           push,
   input  logic                           pop,
   input  logic [WIDTH-1:0]               wdata,
   output logic [WIDTH-1:0]               rdata,
   output logic                           full,
   output logic                           empty,
   output logic [$clog2(DEPTH+1)-1:0]     count
);
   import uart_pkg::*;

   localparam int c_aw = $clog2(DEPTH);
   localparam int c_cw = count_width(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [c_aw-1:0]  r_wr_ptr;
   logic [c_aw-1:0]  r_rd_ptr;
   logic [c_cw-1:0]  r_count;
   logic             w_wr_en;
   logic             w_rd_en;

   // Fullness and emptiness come from the registered count, so a push into a
   // full queue is refused even when a pop happens in the same cycle.
   assign full    = (r_count == c_cw'(DEPTH));
   assign empty   = (r_count == '0);
   assign w_wr_en = push & ~full;
   assign w_rd_en = pop & ~empty;
   assign rdata   = r_mem[r_rd_ptr];
   assign count   = r_count;

   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         r_mem[r_wr_ptr] <= wdata;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_wr_en) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_rd_en) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_wr_en, w_rd_en})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_tx_fifo: parametrised UART transmitter fed by a push queue. Rev 1.0
// ----------------------------------------------------------------------------
module uart_tx_fifo #(
   parameter int DATA_BITS  = 8,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic                                tick,
   input  logic                                start,
   input  logic [DATA_BITS-1:0]                din,
   output logic                                tx_ready,
   output logic                                busy,
   output logic                                overflow,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]     fifo_count,
   output logic                                dout
);
   import uart_pkg::*;

   localparam int   c_bcw     = $clog2(DATA_BITS);
   localparam logic c_par_inv = (PARITY_ODD == uart_pkg::PARITY_ODD);

   if ((DATA_BITS < 5) || (DATA_BITS > 9)) begin : g_bad_data_bits
      $error("uart_tx_fifo: DATA_BITS must be 5..9");
   end
   if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop_bits
      $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
   end
   if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("uart_tx_fifo: FIFO_DEPTH must be a power of two, at least 2");
   end

   tx_state_t            r_state;
   logic [DATA_BITS-1:0] r_shift;
   logic [c_bcw-1:0]     r_bit_cnt;
   logic                 r_stop_cnt;
   logic                 r_parity;
   logic [DATA_BITS-1:0] w_head;
   logic                 w_full;
   logic                 w_empty;
   logic                 w_last_stop;
   logic                 w_pop;

   sync_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (start),
      .pop   (w_pop),
      .wdata (din),
      .rdata (w_head),
      .full  (w_full),
      .empty (w_empty),
      .count (fifo_count)
   );

   assign tx_ready    = ~w_full;
   assign w_last_stop = (r_stop_cnt == 1'(STOP_BITS - 1));
   // Head is taken on a tick from IDLE or from the final stop bit, which is
   // what lets queued frames follow each other with no idle gap.
   assign w_pop = tick & ~w_empty &
                  ((r_state == ST_IDLE) | ((r_state == ST_STOP) & w_last_stop));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         overflow <= 1'b0;
      end else begin
         overflow <= start & w_full;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_shift    <= '1;
         r_bit_cnt  <= '0;
         r_stop_cnt <= 1'b0;
         r_parity   <= 1'b0;
         dout       <= 1'b1;
         busy       <= 1'b0;
      end else if (tick) begin
         case (r_state)
            ST_IDLE: begin
               if (w_pop) begin
                  r_shift  <= w_head;
                  r_parity <= (^w_head) ^ c_par_inv;
                  r_state  <= ST_START;
                  dout     <= 1'b0;
                  busy     <= 1'b1;
               end
            end
            ST_START: begin
               r_state   <= ST_DATA;
               dout      <= r_shift[0];
               r_shift   <= {1'b1, r_shift[DATA_BITS-1:1]};
               r_bit_cnt <= '0;
            end
            ST_DATA: begin
               if (r_bit_cnt == c_bcw'(DATA_BITS - 1)) begin
                  r_stop_cnt <= 1'b0;
                  if (PARITY_EN != 0) begin
                     r_state <= ST_PARITY;
                     dout    <= r_parity;
                  end else begin
                     r_state <= ST_STOP;
                     dout    <= 1'b1;
                  end
               end else begin
                  dout      <= r_shift[0];
                  r_shift   <= {1'b1, r_shift[DATA_BITS-1:1]};
                  r_bit_cnt <= r_bit_cnt + 1'b1;
               end
            end
            ST_PARITY: begin
               r_state    <= ST_STOP;
               r_stop_cnt <= 1'b0;
               dout       <= 1'b1;
            end
            ST_STOP: begin
               if (!w_last_stop) begin
                  r_stop_cnt <= 1'b1;
               end else if (w_pop) begin
                  r_shift  <= w_head;
                  r_parity <= (^w_head) ^ c_par_inv;
                  r_state  <= ST_START;
                  dout     <= 1'b0;
               end else begin
                  r_state <= ST_IDLE;
                  busy    <= 1'b0;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               dout    <= 1'b1;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
